ram0_rr_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit words, 14-bit word address, 10000 words, byte enables, unregistered 1-cycle read output) between two Avalon-MM requesters, e.g. the CPU data master and a DMA engine. It issues at most one RAM command per cycle, holds off the losing master with waitrequest, and returns read data with a fixed one-cycle latency via readdatavalid. Out-of-range accesses are blocked and flagged.

---
 rtl/ram0_rr_arbiter.sv | 113 +++++++++++
 tb/tb_ram0_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram0_rr_arbiter.sv
// rtl/ram0_rr_arbiter.sv - two-master round-robin arbiter in front of the single-port on-chip RAM
module ram0_rr_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  output logic                  oor_error
);

  localparam int BE_W = DATA_W / 8;

  logic              req0, req1;
  logic              gnt0, gnt1, any_gnt;
  logic              last_grant;
  logic              sel_write, sel_in_range;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic              rv0, rv1, rd_oor;

  // Round-robin grant: a lone requester wins, a conflict goes to the master not served last.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !freeze) begin
      gnt0 = req0 & (~req1 | last_grant);
      gnt1 = req1 & (~req0 | ~last_grant);
    end
    any_gnt = gnt0 | gnt1;
  end

  // Steer the winner's command to the RAM; out-of-range commands never reach chipselect.
  always_comb begin
    sel_addr     = gnt1 ? m1_address    : m0_address;
    sel_be       = gnt1 ? m1_byteenable : m0_byteenable;
    sel_wdata    = gnt1 ? m1_writedata  : m0_writedata;
    sel_write    = gnt1 ? m1_write      : m0_write;
    sel_in_range = 32'(sel_addr) < 32'(NUM_WORDS);

    m0_waitrequest = ~gnt0;
    m1_waitrequest = ~gnt1;
    ram_address    = any_gnt ? sel_addr  : addr_q;
    ram_byteenable = any_gnt ? sel_be    : be_q;
    ram_writedata  = any_gnt ? sel_wdata : wdata_q;
    ram_chipselect = any_gnt & sel_in_range;
    ram_write      = any_gnt & sel_write;
    ram_clken      = ~reset;
  end

  // Read return path: one-cycle strobe, out-of-range reads return zero.
  always_comb begin
    m0_readdatavalid = rv0;
    m1_readdatavalid = rv1;
    m0_readdata      = (rv0 && !rd_oor) ? ram_readdata : '0;
    m1_readdata      = (rv1 && !rd_oor) ? ram_readdata : '0;
  end

  // Arbitration history, RAM-port hold registers, read pipeline and sticky range error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
      rd_oor     <= 1'b0;
      oor_error  <= 1'b0;
    end else begin
      rv0    <= gnt0 & ~m0_write;
      rv1    <= gnt1 & ~m1_write;
      rd_oor <= any_gnt & ~sel_in_range;
      if (any_gnt) begin
        last_grant <= gnt1;
        addr_q     <= sel_addr;
        be_q       <= sel_be;
        wdata_q    <= sel_wdata;
        if (!sel_in_range) begin
          oor_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram0_rr_arbiter.sv
// tb/tb_ram0_rr_arbiter.sv - scoreboard bench for ram0_rr_arbiter with a RAM model and reference model
module tb_ram0_rr_arbiter;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 10000;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic freeze = 1'b0;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  logic        oor_error;

  ram0_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .oor_error(oor_error)
  );

  always #5 clk = ~clk;

  // Physical RAM seen by the DUT: registered address, unregistered q.
  logic [31:0] ram [DEPTH];
  logic [13:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    if (ram_clken) ram_addr_q <= ram_address;
  end
  assign ram_readdata = ram[ram_addr_q];

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          model_last = 1;
  logic        model_oor = 1'b0;
  typedef struct { int m; logic [31:0] d; } rd_t;
  rd_t         sbq[$];

  logic exp_wait0 = 1, exp_wait1 = 1, exp_cs = 0, exp_we = 0, exp_clken = 0, exp_oor = 0;
  logic mon_en = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, then let the model decide the outcome.
  task automatic step(input logic frz, input logic rst_i,
                      input logic r0, input logic w0, input logic [13:0] a0,
                      input logic [3:0] be0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [13:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1);
    int gnt;
    logic [13:0] a;
    logic [3:0] be;
    logic [31:0] d;
    logic w;
    @(posedge clk);
    #1;
    reset = rst_i; freeze = frz;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    if (rst_i) begin
      sbq.delete();
      model_last = 1;
      model_oor = 1'b0;
    end
    exp_oor = model_oor;
    gnt = -1;
    if (!rst_i && !frz) begin
      if ((r0 | w0) && (r1 | w1)) gnt = (model_last == 0) ? 1 : 0;
      else if (r0 | w0)           gnt = 0;
      else if (r1 | w1)           gnt = 1;
    end
    a  = (gnt == 1) ? a1  : a0;
    be = (gnt == 1) ? be1 : be0;
    d  = (gnt == 1) ? d1  : d0;
    w  = (gnt == 1) ? w1  : w0;
    exp_wait0 = (gnt != 0);
    exp_wait1 = (gnt != 1);
    exp_cs    = (gnt >= 0) && (a < NUM_WORDS);
    exp_we    = (gnt >= 0) && w;
    exp_clken = !rst_i;
    if (gnt >= 0) begin
      model_last = gnt;
      if (a >= NUM_WORDS) model_oor = 1'b1;
      if (w) begin
        if (a < NUM_WORDS)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        sbq.push_back('{m: gnt, d: (a < NUM_WORDS) ? ref_mem[a] : 32'h0});
      end
    end
    mon_en = 1;
  endtask

  task automatic idle(input logic rst_i);
    step(0, rst_i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: sample mid-cycle, compare handshakes and pop the scoreboard on each strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      rd_t e;
      chk("m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, exp_wait0});
      chk("m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, exp_wait1});
      chk("ram_chipselect", {31'b0, ram_chipselect}, {31'b0, exp_cs});
      chk("ram_write", {31'b0, ram_write}, {31'b0, exp_we});
      chk("ram_clken", {31'b0, ram_clken}, {31'b0, exp_clken});
      chk("oor_error", {31'b0, oor_error}, {31'b0, exp_oor});
      if (m0_readdatavalid && m1_readdatavalid) chk("dual_valid", 32'd1, 32'd0);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rd_master", m1_readdatavalid ? 32'd1 : 32'd0, e.m);
          chk("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.d);
        end
      end
      if (!m0_readdatavalid) chk("m0_readdata_idle", m0_readdata, 32'h0);
      if (!m1_readdatavalid) chk("m1_readdata_idle", m1_readdata, 32'h0);
    end
  end

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = i * 32'h9E37_79B1;
      ref_mem[i] = i * 32'h9E37_79B1;
    end
    idle(1); idle(1); idle(0);
    // Write then read back-to-back.
    step(0, 0, 0, 1, 14'd5, 4'hF, 32'hA5A5_0001, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 14'd5, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Continuous conflicting reads alternate.
    for (int i = 0; i < 6; i++)
      step(0, 0, 1, 0, 14'(10 + i), 4'hF, 0, 1, 0, 14'(20 + i), 4'hF, 0);
    // Partial byte write merge.
    step(0, 0, 0, 1, 14'd7, 4'hF, 32'h1111_1111, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 14'd7, 4'h2, 32'h0000_3C00);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 14'd7, 4'hF, 0);
    // Out-of-range write and read.
    step(0, 0, 0, 1, 14'd10000, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 14'd10000, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Freeze after a read grant.
    step(0, 0, 1, 0, 14'd3, 4'hF, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 14'd3, 4'hF, 0, 1, 0, 14'd4, 4'hF, 0);
    step(1, 0, 1, 0, 14'd3, 4'hF, 0, 1, 0, 14'd4, 4'hF, 0);
    step(0, 0, 1, 0, 14'd3, 4'hF, 0, 1, 0, 14'd4, 4'hF, 0);
    step(0, 0, 1, 0, 14'd3, 4'hF, 0, 1, 0, 14'd4, 4'hF, 0);
    // Reset right after a read grant.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 14'd8, 4'hF, 0);
    step(0, 1, 1, 0, 14'd9, 4'hF, 0, 1, 0, 14'd8, 4'hF, 0);
    step(0, 0, 1, 0, 14'd9, 4'hF, 0, 1, 0, 14'd8, 4'hF, 0);
    step(0, 0, 1, 0, 14'd9, 4'hF, 0, 1, 0, 14'd8, 4'hF, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [13:0] ra0, ra1;
      int p0, p1;
      p0 = $urandom_range(0, 19);
      p1 = $urandom_range(0, 19);
      ra0 = (p0 < 18) ? 14'(p0) : 14'(NUM_WORDS + $urandom_range(0, 3));
      ra1 = (p1 < 18) ? 14'(p1) : 14'(NUM_WORDS + $urandom_range(0, 3));
      step(($urandom_range(0, 9) == 0), 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ra0,
           4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ra1,
           4'($urandom), $urandom);
    end
    idle(0); idle(0); idle(0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_contents", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
